// File: rtl/sram2p_masked.sv
`default_nettype none
// ============================================================================
// Module   : sram2p_masked
// Purpose  : True dual-port synchronous SRAM model with per-bit write masks,
//            deterministic read-during-write (read-first or write-first),
//            optional output pipeline register, per-port read-valid strobes
//            and an optional post-reset clear sequencer.
// Ports    : CLK, RST          - clock, synchronous active-high reset
//            BUSY              - clear sequencer running, ports ignored
//            COLL              - pulse: both ports wrote the same address
//            CEp/Ap/Dp/WEp/WEMp- port p enable, address, data, write, mask
//            Qp/QVp            - port p read data and read-data valid
// Revision : 1.0 - initial release
// ============================================================================
module sram2p_masked #(
   parameter int DW         = 16,
   parameter int AW         = 10,
   parameter int RD_MODE    = 0,
   parameter int OUT_REG    = 0,
   parameter int CLR_ON_RST = 1
) (
   input  logic          CLK,
   input  logic          RST,
   output logic          BUSY,
   output logic          COLL,
   input  logic          CE0,
   input  logic [AW-1:0] A0,
   input  logic [DW-1:0] D0,
   input  logic          WE0,
   input  logic [DW-1:0] WEM0,
   output logic [DW-1:0] Q0,
   output logic          QV0,
   input  logic          CE1,
   input  logic [AW-1:0] A1,
   input  logic [DW-1:0] D1,
   input  logic          WE1,
   input  logic [DW-1:0] WEM1,
   output logic [DW-1:0] Q1,
   output logic          QV1
);

   localparam int DEPTH = 1 << AW;

   typedef enum logic [0:0] {
      S_CLEAR = 1'b0,
      S_READY = 1'b1
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [AW-1:0] r_clr_addr;
   logic [AW-1:0] w_clr_addr_nxt;
   logic          w_clr_we;

   logic [DW-1:0] r_mem [DEPTH];

   // ------------------------------------------------------------------------
   // Clear sequencer. Reset parks the machine at the entry state with the
   // counter at 0; the first word is zeroed on the first edge with RST low,
   // so BUSY stays high for exactly DEPTH cycles after release.
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         if (CLR_ON_RST != 0) begin
            r_state <= S_CLEAR;
         end else begin
            r_state <= S_READY;
         end
         r_clr_addr <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_clr_addr <= w_clr_addr_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_clr_addr_nxt = r_clr_addr;
      w_clr_we       = 1'b0;
      case (r_state)
         S_CLEAR: begin
            w_clr_we       = 1'b1;
            w_clr_addr_nxt = r_clr_addr + AW'(1);
            if (r_clr_addr == '1) begin
               w_state_nxt = S_READY;
            end
         end
         default: begin
         end
      endcase
   end

   assign BUSY = (r_state != S_READY);

   // ------------------------------------------------------------------------
   // Access qualification and merged write data
   // ------------------------------------------------------------------------
   logic          w_acc0, w_acc1;
   logic          w_wr0, w_wr1;
   logic          w_same;
   logic [DW-1:0] w_m0, w_m1;
   logic [DW-1:0] w_x0, w_x1;
   logic [DW-1:0] w_old0, w_old1;
   logic [DW-1:0] w_post0, w_post1;
   logic [DW-1:0] w_rd0, w_rd1;

   assign w_acc0 = CE0 & ~BUSY & ~RST;
   assign w_acc1 = CE1 & ~BUSY & ~RST;
   assign w_wr0  = w_acc0 & WE0;
   assign w_wr1  = w_acc1 & WE1;
   assign w_same = (A0 == A1);

   assign w_m0 = w_wr0 ? WEM0 : '0;
   assign w_m1 = w_wr1 ? WEM1 : '0;
   // Mask of the other port's write landing on this port's address
   assign w_x0 = w_same ? w_m0 : '0;
   assign w_x1 = w_same ? w_m1 : '0;

   assign w_old0 = r_mem[A0];
   assign w_old1 = r_mem[A1];

   // Word at each address after both ports' writes; on a shared address
   // port 0 owns every bit in its mask, port 1 only the remaining bits.
   assign w_post0 = (w_old0 & ~(w_m0 | w_x1)) | (D0 & w_m0) | (D1 & w_x1 & ~w_m0);
   assign w_post1 = (w_old1 & ~(w_m1 | w_x0)) | (D1 & w_m1 & ~w_x0) | (D0 & w_x0);

   assign w_rd0 = (RD_MODE != 0) ? w_post0 : w_old0;
   assign w_rd1 = (RD_MODE != 0) ? w_post1 : w_old1;

   // Array storage carries no reset: contents survive RST unless cleared.
   always_ff @(posedge CLK) begin
      if (w_clr_we && !RST) begin
         r_mem[r_clr_addr] <= '0;
      end
      if (w_wr0) begin
         r_mem[A0] <= w_post0;
      end
      if (w_wr1) begin
         r_mem[A1] <= w_post1;
      end
   end

   // ------------------------------------------------------------------------
   // First read stage and collision flag
   // ------------------------------------------------------------------------
   logic [DW-1:0] r_q0_s1, r_q1_s1;
   logic          r_qv0_s1, r_qv1_s1;
   logic          r_coll;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_q0_s1  <= '0;
         r_q1_s1  <= '0;
         r_qv0_s1 <= 1'b0;
         r_qv1_s1 <= 1'b0;
         r_coll   <= 1'b0;
      end else begin
         r_qv0_s1 <= w_acc0;
         r_qv1_s1 <= w_acc1;
         if (w_acc0) begin
            r_q0_s1 <= w_rd0;
         end
         if (w_acc1) begin
            r_q1_s1 <= w_rd1;
         end
         r_coll <= w_wr0 & w_wr1 & w_same;
      end
   end

   assign COLL = r_coll;

   // ------------------------------------------------------------------------
   // Optional output pipeline stage; data holds when no valid word arrives.
   // ------------------------------------------------------------------------
   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [DW-1:0] r_q0_s2, r_q1_s2;
         logic          r_qv0_s2, r_qv1_s2;

         always_ff @(posedge CLK) begin
            if (RST) begin
               r_q0_s2  <= '0;
               r_q1_s2  <= '0;
               r_qv0_s2 <= 1'b0;
               r_qv1_s2 <= 1'b0;
            end else begin
               r_qv0_s2 <= r_qv0_s1;
               r_qv1_s2 <= r_qv1_s1;
               if (r_qv0_s1) begin
                  r_q0_s2 <= r_q0_s1;
               end
               if (r_qv1_s1) begin
                  r_q1_s2 <= r_q1_s1;
               end
            end
         end

         assign Q0  = r_q0_s2;
         assign QV0 = r_qv0_s2;
         assign Q1  = r_q1_s2;
         assign QV1 = r_qv1_s2;
      end else begin : g_out_direct
         assign Q0  = r_q0_s1;
         assign QV0 = r_qv0_s1;
         assign Q1  = r_q1_s1;
         assign QV1 = r_qv1_s1;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sram2p_masked.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram2p_masked
// Purpose  : Self-checking bench for sram2p_masked. Two instances (AW=4):
//            dut_a read-first / no output register, dut_b write-first /
//            output register, both with clear-on-reset, driven in parallel.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram2p_masked;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        ce0, we0, ce1, we1;
   logic [3:0]  a0, a1;
   logic [15:0] d0, m0, d1, m1;

   logic        busy_a, coll_a, qv0_a, qv1_a;
   logic [15:0] q0_a, q1_a;
   logic        busy_b, coll_b, qv0_b, qv1_b;
   logic [15:0] q0_b, q1_b;

   sram2p_masked #(.DW(16), .AW(4), .RD_MODE(0), .OUT_REG(0), .CLR_ON_RST(1)) dut_a (
      .CLK(clk), .RST(rst), .BUSY(busy_a), .COLL(coll_a),
      .CE0(ce0), .A0(a0), .D0(d0), .WE0(we0), .WEM0(m0), .Q0(q0_a), .QV0(qv0_a),
      .CE1(ce1), .A1(a1), .D1(d1), .WE1(we1), .WEM1(m1), .Q1(q1_a), .QV1(qv1_a)
   );

   sram2p_masked #(.DW(16), .AW(4), .RD_MODE(1), .OUT_REG(1), .CLR_ON_RST(1)) dut_b (
      .CLK(clk), .RST(rst), .BUSY(busy_b), .COLL(coll_b),
      .CE0(ce0), .A0(a0), .D0(d0), .WE0(we0), .WEM0(m0), .Q0(q0_b), .QV0(qv0_b),
      .CE1(ce1), .A1(a1), .D1(d1), .WE1(we1), .WEM1(m1), .Q1(q1_b), .QV1(qv1_b)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Behavioural model: word array, clear countdown, and the expected
   // outputs of both instances after each rising edge.
   // ------------------------------------------------------------------------
   logic [15:0] mmem [16];
   int          clr_left;
   bit          started = 1'b0;
   logic [15:0] ea_q0, ea_q1, eb_q0, eb_q1, eb_s1q0, eb_s1q1;
   logic        ea_qv0, ea_qv1, eb_qv0, eb_qv1, eb_s1v0, eb_s1v1;
   logic        e_coll, e_busy;

   initial begin
      logic        acc0, acc1;
      logic [15:0] old0, old1, post0, post1;
      forever begin
         @(posedge clk);
         if (rst) begin
            clr_left = 16;
            ea_q0 = 0; ea_q1 = 0; ea_qv0 = 0; ea_qv1 = 0;
            eb_q0 = 0; eb_q1 = 0; eb_qv0 = 0; eb_qv1 = 0;
            eb_s1q0 = 0; eb_s1q1 = 0; eb_s1v0 = 0; eb_s1v1 = 0;
            e_coll = 0; e_busy = 1;
         end else begin
            acc0 = 0;
            acc1 = 0;
            if (clr_left > 0) begin
               clr_left--;
               if (clr_left == 0) begin
                  for (int i = 0; i < 16; i++) mmem[i] = 16'h0000;
               end
            end else begin
               acc0 = ce0;
               acc1 = ce1;
            end
            old0 = mmem[a0];
            old1 = mmem[a1];
            // Port 1 applied first, port 0 on top: port 0 wins shared bits.
            if (acc1 && we1) mmem[a1] = (mmem[a1] & ~m1) | (d1 & m1);
            if (acc0 && we0) mmem[a0] = (mmem[a0] & ~m0) | (d0 & m0);
            post0 = mmem[a0];
            post1 = mmem[a1];
            e_coll = acc0 && we0 && acc1 && we1 && (a0 == a1);
            ea_qv0 = acc0;
            ea_qv1 = acc1;
            if (acc0) ea_q0 = old0;
            if (acc1) ea_q1 = old1;
            eb_qv0 = eb_s1v0;
            eb_qv1 = eb_s1v1;
            if (eb_s1v0) eb_q0 = eb_s1q0;
            if (eb_s1v1) eb_q1 = eb_s1q1;
            eb_s1v0 = acc0;
            eb_s1v1 = acc1;
            if (acc0) eb_s1q0 = post0;
            if (acc1) eb_s1q1 = post1;
            e_busy = (clr_left > 0);
         end
         started = 1'b1;
      end
   end

   // Cycle-by-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         if (started) begin
            chk("a.Q0", q0_a, ea_q0);     chk("a.QV0", qv0_a, ea_qv0);
            chk("a.Q1", q1_a, ea_q1);     chk("a.QV1", qv1_a, ea_qv1);
            chk("a.COLL", coll_a, e_coll); chk("a.BUSY", busy_a, e_busy);
            chk("b.Q0", q0_b, eb_q0);     chk("b.QV0", qv0_b, eb_qv0);
            chk("b.Q1", q1_b, eb_q1);     chk("b.QV1", qv1_b, eb_qv1);
            chk("b.COLL", coll_b, e_coll); chk("b.BUSY", busy_b, e_busy);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not end, n_chk %0d", n_chk);
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------------
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle;
      ce0 = 0; we0 = 0; a0 = 0; d0 = 0; m0 = 0;
      ce1 = 0; we1 = 0; a1 = 0; d1 = 0; m1 = 0;
   endtask

   task automatic acc(input logic c0, input logic w0, input logic [3:0] ad0,
                      input logic [15:0] dd0, input logic [15:0] mm0,
                      input logic c1, input logic w1, input logic [3:0] ad1,
                      input logic [15:0] dd1, input logic [15:0] mm1);
      ce0 = c0; we0 = w0; a0 = ad0; d0 = dd0; m0 = mm0;
      ce1 = c1; we1 = w1; a1 = ad1; d1 = dd1; m1 = mm1;
      tick;
      set_idle;
   endtask

   task automatic count_busy(output int na, output int nb);
      na = 0;
      nb = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (busy_a) na++;
         if (busy_b) nb++;
         if (!busy_a && !busy_b) break;
      end
   endtask

   // ------------------------------------------------------------------------
   // Directed sequence
   // ------------------------------------------------------------------------
   initial begin
      int na, nb;
      rst = 1'b1;
      set_idle;
      tick;
      @(negedge clk);
      chk("rst_a_q0", q0_a, 16'h0000);
      chk("rst_a_qv0", qv0_a, 1'b0);
      chk("rst_a_busy", busy_a, 1'b1);
      chk("rst_a_coll", coll_a, 1'b0);
      chk("rst_b_q1", q1_b, 16'h0000);
      chk("rst_b_qv1", qv1_b, 1'b0);
      chk("rst_b_busy", busy_b, 1'b1);
      tick;
      rst = 1'b0;
      count_busy(na, nb);
      chk("clr_len_a", na, 16);
      chk("clr_len_b", nb, 16);

      // Every word reads back zero after the clear
      for (int i = 0; i < 16; i++) acc(1, 0, 4'(i), 0, 0, 1, 0, 4'(15 - i), 0, 0);
      @(negedge clk);
      chk("clr_rd_a_q0", q0_a, 16'h0000);
      chk("clr_rd_a_qv0", qv0_a, 1'b1);

      // Masked write
      acc(1, 1, 4'd5, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0, 0);
      acc(1, 1, 4'd5, 16'h0000, 16'h00FF, 0, 0, 0, 0, 0);
      acc(0, 0, 0, 0, 0, 1, 0, 4'd5, 0, 0);
      @(negedge clk);
      chk("mask_a_q1", q1_a, 16'hFF00);
      @(negedge clk);
      chk("mask_b_q1", q1_b, 16'hFF00);

      // Cross-port read during write
      acc(1, 1, 4'd3, 16'h1111, 16'hFFFF, 0, 0, 0, 0, 0);
      acc(1, 1, 4'd3, 16'h2222, 16'hFFFF, 1, 0, 4'd3, 0, 0);
      @(negedge clk);
      chk("rdw_a_q1", q1_a, 16'h1111);
      @(negedge clk);
      chk("rdw_b_q1", q1_b, 16'h2222);

      // Write collision on address 7
      acc(1, 1, 4'd7, 16'hAAAA, 16'hF0F0, 1, 1, 4'd7, 16'h5555, 16'hFFFF);
      @(negedge clk);
      chk("coll_a_pulse", coll_a, 1'b1);
      chk("coll_b_pulse", coll_b, 1'b1);
      @(negedge clk);
      chk("coll_a_end", coll_a, 1'b0);
      acc(1, 0, 4'd7, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("coll_a_word", q0_a, 16'hA5A5);

      // Back-to-back reads through the output register
      for (int i = 0; i < 8; i++) acc(1, 1, 4'(i), 16'(16'h0100 + i), 16'hFFFF, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         if (i < 8) begin
            ce1 = 1;
            a1  = 4'(i);
         end else begin
            ce1 = 0;
         end
         tick;
         @(negedge clk);
         if (i >= 1 && i <= 8) begin
            chk("stream_b_qv1", qv1_b, 1'b1);
            chk("stream_b_q1", q1_b, 32'h0100 + i - 1);
         end
         if (i == 9) chk("stream_b_qv1_end", qv1_b, 1'b0);
      end
      set_idle;

      // Fill with non-zero data, then reset while a pipelined read is in flight
      for (int i = 0; i < 8; i++)
         acc(1, 1, 4'(i), 16'(16'hBEE0 + i), 16'hFFFF, 1, 1, 4'(i + 8), 16'(16'hBEE8 + i), 16'hFFFF);
      acc(0, 0, 0, 0, 0, 1, 0, 4'd2, 0, 0);
      rst = 1'b1;
      tick;
      @(negedge clk);
      chk("drop_b_qv1", qv1_b, 1'b0);
      tick;
      rst = 1'b0;
      repeat (9) tick;
      // Reset lands on the edge that would clear address 9
      rst = 1'b1;
      tick;
      rst = 1'b0;
      count_busy(na, nb);
      chk("reclr_len_a", na, 16);
      chk("reclr_len_b", nb, 16);
      for (int i = 0; i < 16; i++) acc(1, 0, 4'(i), 0, 0, 1, 0, 4'(15 - i), 0, 0);
      acc(1, 0, 4'd9, 0, 0, 1, 0, 4'd15, 0, 0);
      @(negedge clk);
      chk("reclr_a_q0", q0_a, 16'h0000);
      chk("reclr_a_q1", q1_a, 16'h0000);
      @(negedge clk);
      chk("reclr_b_q0", q0_b, 16'h0000);
      chk("reclr_b_q1", q1_b, 16'h0000);

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sram2p_masked.md
# sram2p_masked

Parametrised true dual-port synchronous SRAM model for the accelerator's on-chip buffers: two independent read/write ports on one clock, per-bit write masks, deterministic read-during-write behaviour, optional output pipeline register, per-port read-valid strobes and an optional post-reset clear sequencer. It replaces the fixed 1024x16 dual-port macros and gives identical behaviour in simulation and synthesis.

## Interface
- DW, 16: data width in bits.
- AW, 10: address width; depth = 2**AW words.
- RD_MODE, 0: 0 = read-first (Q returns old word), 1 = write-first (Q returns post-write word).
- OUT_REG, 0: 1 adds one output pipeline stage on Q/QV.
- CLR_ON_RST, 1: 1 = zero the whole array after reset; 0 = array contents untouched by reset.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  synchronous, active-high reset.
- BUSY  out  1  high while the clear sequencer runs; ports ignored.
- COLL  out  1  one-cycle pulse: both ports wrote the same address in the same accepted cycle.
- CE0  in  1  port 0 access enable.
- A0  in  AW  port 0 address.
- D0  in  DW  port 0 write data.
- WE0  in  1  port 0 write enable (qualified by CE0).
- WEM0  in  DW  port 0 bit mask; 1 = bit written.
- Q0  out  DW  port 0 read data.
- QV0  out  1  port 0 read-data valid.
- CE1, A1, D1, WE1, WEM1, Q1, QV1: port 1, identical to port 0.

## Operation
- Access accepted on port p when CEp=1 and BUSY=0. Accepted access always reads; writes too if WEp=1.
- Masked write: mem[A] <= (mem[A] & ~WEMp) | (Dp & WEMp). WEMp=0 with WEp=1 reads, leaves the word unchanged.
- Read data per RD_MODE, for same-port and cross-port writes to the read address in that cycle:
  - RD_MODE=0: Q is the word before this cycle's writes.
  - RD_MODE=1: Q is the word after all this cycle's writes, both ports, merged as below.
- Both ports write the same address: bits in WEM0 take D0 (port 0 wins); bits only in WEM1 take D1; other bits unchanged. COLL=1 on the next cycle, whatever the masks. No COLL for a write/read or read/read on the same address.
- CEp=0 or BUSY=1: Qp holds its last value, QVp=0.
- Clear sequencer states:
  - RESET (RST=1): all outputs forced to reset values; clear counter=0.
  - CLEAR (CLR_ON_RST=1 only): entered the cycle after RST falls. One word written to zero per cycle at addresses 0..2**AW-1, BUSY=1. Leaves after the last address.
  - READY: normal operation, BUSY=0.
  - With CLR_ON_RST=0, RESET goes straight to READY.
- RST asserted mid-CLEAR: back to RESET; clearing restarts at address 0 after release.
- RST asserted in READY: the array is not modified (unless a new clear follows); an in-flight pipelined read is dropped (QV=0).
- Reset values: Q0=Q1=0, QV0=QV1=0, COLL=0, BUSY=1 if CLR_ON_RST else 0.

## Timing
- Read latency: OUT_REG=0, Q/QV valid on the edge after the access (1 cycle). OUT_REG=1, 2 cycles.
- Fully pipelined: one accepted access per port per cycle, no bubbles.
- COLL is aligned 1 cycle after the colliding access, independent of OUT_REG.
- Clear duration: exactly 2**AW cycles of BUSY=1, starting the cycle after RST deasserts. First accepted access is in the cycle BUSY is low.
- A write is visible to any read issued in a later cycle, on either port, in both modes.

## Test plan
- Reset/clear (AW=4, CLR_ON_RST=1): after RST release, BUSY high exactly 16 cycles. Then reads of all 16 addresses return 0 with QV=1 one cycle later.
- Masked write: write 0xFFFF to addr 5, then D=0x0000 with WEM=0x00FF to addr 5. Read returns 0xFF00.
- Read-during-write, cross-port: addr 3 holds 0x1111; port 0 writes 0x2222 while port 1 reads 3. Q1 must be 0x1111 with RD_MODE=0 and 0x2222 with RD_MODE=1.
- Write collision: port 0 writes 0xAAAA/WEM 0xF0F0 and port 1 writes 0x5555/WEM 0xFFFF to addr 7, old value 0x0000. Result 0xA5A5; COLL pulses one cycle.
- OUT_REG=1: back-to-back reads of addresses 0..7 on port 1. Data returns 2 cycles later, one word per cycle, QV1 continuous, no gaps.
- Reset mid-clear: RST pulsed at clear address 9 (AW=4). BUSY restarts, lasts a full 16 cycles, all words read 0.
